// File: rtl/logic_pipe_pkg.sv
// rtl/logic_pipe_pkg.sv - operation codes and per-bit operation evaluation for logic_pipe
package logic_pipe_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   // Evaluated per bit so the top level can apply it to any operand width.
   function automatic logic eval_bit(input logic a, input logic b, input logic [1:0] op);
      logic res;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         default: res = ~(a & b);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// rtl/logic_pipe_stage.sv - one valid/data/reduction register of the logic_pipe chain
module logic_pipe_stage
   import logic_pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         prev_valid,
   input  logic [W-1:0] prev_data,
   input  logic         prev_red,
   input  logic         next_ready,
   output logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         red
);

   assign ready = !valid || next_ready;

   // Data only moves with a valid beat, so a bubble leaves the old payload in place.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         red   <= 1'b0;
      end else if (ready) begin
         valid <= prev_valid;
         if (prev_valid) begin
            data <= prev_data;
            red  <= prev_red;
         end
      end
   end

endmodule

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - registered bitwise logic unit with DEPTH-stage valid/ready pipeline
module logic_pipe
   import logic_pipe_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [W-1:0]     ain,
   input  logic [W-1:0]     bin,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     logic_out,
   output logic             and_all,
   output logic [CNT_W-1:0] out_count
);

   logic [W-1:0] result;
   logic         stg_valid [0:DEPTH];
   logic [W-1:0] stg_data  [0:DEPTH];
   logic         stg_red   [0:DEPTH];
   logic         stg_ready [1:DEPTH+1];

   always_comb begin
      result = '0;
      for (int i = 0; i < W; i++) begin
         result[i] = eval_bit(ain[i], bin[i], op);
      end
   end

   // Index 0 is the producer side; index DEPTH+1 of the ready chain is the consumer.
   assign stg_valid[0]       = in_valid;
   assign stg_data[0]        = result;
   assign stg_red[0]         = &result;
   assign stg_ready[DEPTH+1] = out_ready;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      logic_pipe_stage #(.W(W)) u_stage (
         .clock      (clock),
         .reset      (reset),
         .prev_valid (stg_valid[k-1]),
         .prev_data  (stg_data[k-1]),
         .prev_red   (stg_red[k-1]),
         .next_ready (stg_ready[k+1]),
         .ready      (stg_ready[k]),
         .valid      (stg_valid[k]),
         .data       (stg_data[k]),
         .red        (stg_red[k])
      );
   end

   assign in_ready  = stg_ready[1];
   assign out_valid = stg_valid[DEPTH];
   assign logic_out = stg_data[DEPTH];
   assign and_all   = stg_red[DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         out_count <= '0;
      end else if (out_valid && out_ready) begin
         out_count <= out_count + 1'b1;
      end
   end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, registered bitwise logic unit: the successor to the single-bit registered AND gate. It applies a run-time-selected operation (AND/OR/XOR/NAND) to two W-bit operands and passes the result through a DEPTH-stage valid/ready pipeline with backpressure. It also counts delivered results. It sits between operand producers and downstream consumers in the lab datapath and serves as the standard lab block for handshake and pipelining exercises.

## Interface
- W, default 8: operand and result width (≥1).
- DEPTH, default 2: number of pipeline register stages (≥1).
- CNT_W, default 16: width of the delivered-result counter.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- ain  input  W  operand A.
- bin  input  W  operand B.
- op  input  2  operation: 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NAND (bitwise ~(a&b)).
- in_valid  input  1  ain/bin/op are valid this cycle.
- in_ready  output  1  pipeline accepts the input this cycle.
- out_valid  output  1  logic_out/and_all are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- logic_out  output  W  result of the selected operation.
- and_all  output  1  reduction AND of logic_out, registered alongside it.
- out_count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

## Operation
- The operation is evaluated combinationally on ain/bin/op and captured into stage 1 on accept (in_valid && in_ready). No logic sits after the last register.
- Each stage k holds valid_k, data_k[W] and red_k. red_1 = &result.
- Stage ready: ready_k = !valid_k || ready_(k+1), with ready_(DEPTH+1) = out_ready. in_ready = ready_1. This is a combinational chain with no skid buffer.
- A stage loads from its predecessor when ready_k is 1. valid_k takes the predecessor's valid (stage 1 takes in_valid). Data moves only with valid, so bubbles collapse.
- out_valid = valid_DEPTH, logic_out = data_DEPTH, and_all = red_DEPTH.
- out_count increments by 1 on each cycle with out_valid && out_ready. It wraps from 2^CNT_W-1 to 0.
- op is sampled per transaction, so consecutive beats may use different operations.
- Output stability: while out_valid=1 and out_ready=0, logic_out and and_all hold.

## Timing
- Reset values: in_ready=1 (all stages empty), out_valid=0, logic_out=0, and_all=0, out_count=0, all valid_k=0.
- Reset has priority over all transfers in the same cycle. A reset mid-operation discards in-flight beats, and those beats are not counted.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+DEPTH-1 (visible in cycle n+DEPTH) if no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- Full condition: all DEPTH stages valid and out_ready=0 gives in_ready=0. Occupancy never exceeds DEPTH.
- Simultaneous accept and deliver on a full pipe: when out_ready=1, in_ready=1 in the same cycle. Input is accepted and output delivered on one edge, and occupancy is unchanged.
- in_valid=0 with in_ready=1 loads a bubble (valid_1=0); data_1 may be left unchanged.

## Structure
- Package logic_pipe_pkg: localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11, and the op-evaluation function.
- Sub-module logic_pipe_stage: one valid/data/red register with the ready_k rule, instantiated DEPTH times via generate.
- The top level holds the op decode, the generate loop and the out_count register.

## Test plan
All scenarios use W=8, DEPTH=2, CNT_W=4, out_ready=1 unless noted.
- Reset: hold reset=1 for 2 cycles with in_valid=1 -> out_valid=0, logic_out=8'h00, out_count=0, in_ready=1.
- Op sweep: ain=8'hF0, bin=8'h3C, op=00/01/10/11 on consecutive cycles -> outputs 8'h30, 8'hFC, 8'hCC, 8'hCF arrive back-to-back, the first in cycle 2 after accept. and_all=0 for all four. Then ain=bin=8'hFF with op=AND -> 8'hFF with and_all=1.
- Backpressure: fill with 2 beats, then hold out_ready=0 for 5 cycles -> in_ready=0, logic_out stable, no count change. Release -> both beats delivered in order and out_count advances by 2.
- Simultaneous: full pipe, out_ready=1, in_valid=1 for 10 cycles -> one beat in and one out per cycle, in_ready held at 1.
- Counter wrap: deliver 17 beats -> out_count reads 1.
- Mid-flight reset: accept 2 beats, assert reset one cycle before the first would emerge -> no beat delivered, out_count=0.
